wb_arbiter: RTL

- Write-back arbiter that sits directly upstream of the register file and drives its single write port (`Wn`/`Write`/`Wd`).
- Merges two result sources:
  - the single-cycle ALU path, which has fixed priority;
  - the long-latency load/mul-div path, buffered in a small FIFO and drained into idle write slots.
- Exports a pending-write mask so decode/hazard logic can stall readers of registers whose results are still queued.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 103 ++++++++++
 rtl/wb_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the queued write-back entry type for the write-back arbiter.
package wb_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    typedef struct packed {
        logic          live;
        logic [AW-1:0] wn;
        logic [DW-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of slow-path write-backs with parallel match-and-kill and a
// registered mask of the registers that still have live queued writes.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  wb_entry_t                    i_push_data,
    input  logic                         i_pop,
    input  logic                         i_kill_en,
    input  logic [AW-1:0]                i_kill_wn,
    output wb_entry_t                    o_head_c,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [NREG-1:0]              o_live_mask
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    wb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic [NREG-1:0]  r_mask;

    logic [DEPTH-1:0] w_vld_n;
    logic [DEPTH-1:0] w_live_n;
    logic [AW-1:0]    w_wn_n [DEPTH];
    logic [NREG-1:0]  w_mask_n;
    logic [CW-1:0]    w_count_n;

    // Next slot state: kill matches first, then pop, then push (push is younger than the kill).
    always_comb begin
        w_vld_n = r_vld;
        for (int i = 0; i < DEPTH; i++) begin
            w_live_n[i] = r_mem[i].live;
            w_wn_n[i]   = r_mem[i].wn;
            if (i_kill_en && r_vld[i] && (r_mem[i].wn == i_kill_wn)) begin
                w_live_n[i] = 1'b0;
            end
        end
        if (i_pop) begin
            w_vld_n[r_rd] = 1'b0;
        end
        if (i_push) begin
            w_vld_n[r_wr]  = 1'b1;
            w_live_n[r_wr] = i_push_data.live;
            w_wn_n[r_wr]   = i_push_data.wn;
        end

        w_mask_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int r = 1; r < NREG; r++) begin
                if (w_vld_n[i] && w_live_n[i] && (w_wn_n[i] == AW'(r))) begin
                    w_mask_n[r] = 1'b1;
                end
            end
        end

        case ({i_push, i_pop})
            2'b10:   w_count_n = r_count + CW'(1);
            2'b01:   w_count_n = r_count - CW'(1);
            default: w_count_n = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_vld   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_mask  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].live <= w_live_n[i];
            end
            if (i_push) begin
                r_mem[r_wr].wn <= i_push_data.wn;
                r_mem[r_wr].wd <= i_push_data.wd;
                r_wr           <= r_wr + PW'(1);
            end
            if (i_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            r_vld   <= w_vld_n;
            r_count <= w_count_n;
            r_mask  <= w_mask_n;
        end
    end

    assign o_head_c    = r_mem[r_rd];
    assign o_count     = r_count;
    assign o_live_mask = r_mask;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, slow-path results
// drain from a FIFO into idle slots. Optional direct path with WB_BYPASS_EN.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = wb_pkg::DW,
    parameter int unsigned AW    = wb_pkg::AW
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         AluWrite,
    input  logic [AW-1:0]                AluWn,
    input  logic [DW-1:0]                AluWd,
    input  logic                         LdValid,
    input  logic [AW-1:0]                LdWn,
    input  logic [DW-1:0]                LdWd,
    output logic                         LdReady,
    output logic                         Write,
    output logic [AW-1:0]                Wn,
    output logic [DW-1:0]                Wd,
    output logic [wb_pkg::NREG-1:0]      Pending,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int unsigned CW  = $clog2(DEPTH+1);
    localparam int unsigned EAW = wb_pkg::AW;
    localparam int unsigned EDW = wb_pkg::DW;

    wb_pkg::wb_entry_t         w_push_data;
    wb_pkg::wb_entry_t         w_head;
    logic [CW-1:0]             w_count;
    logic [wb_pkg::NREG-1:0]   w_mask;
    logic                      w_alu_go;
    logic                      w_ld_go;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_bypass;

    logic                      r_write;
    logic [AW-1:0]             r_wn;
    logic [DW-1:0]             r_wd;
    logic                      w_write_n;
    logic [AW-1:0]             w_wn_n;
    logic [DW-1:0]             w_wd_n;

    // Register-0 writes from either source are swallowed here.
    assign w_alu_go = AluWrite && (AluWn != '0);
    assign w_ld_go  = LdValid && LdReady && (LdWn != '0);
    assign w_empty  = (w_count == '0);
    assign w_pop    = !w_alu_go && !w_empty;
    assign LdReady  = Reset_n && (w_count < CW'(DEPTH));

`ifdef WB_BYPASS_EN
    assign w_bypass = w_ld_go && !w_alu_go && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_ld_go && !w_bypass;

    always_comb begin
        w_push_data      = '0;
        w_push_data.live = 1'b1;
        w_push_data.wn   = EAW'(LdWn);
        w_push_data.wd   = EDW'(LdWd);
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (Clock),
        .rst_n       (Reset_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_kill_en   (w_alu_go),
        .i_kill_wn   (EAW'(AluWn)),
        .o_head_c    (w_head),
        .o_count     (w_count),
        .o_live_mask (w_mask)
    );

    // Slot priority: ALU, then FIFO head (killed head pops silently), then bypass.
    always_comb begin
        w_write_n = 1'b0;
        w_wn_n    = r_wn;
        w_wd_n    = r_wd;
        if (w_alu_go) begin
            w_write_n = 1'b1;
            w_wn_n    = AluWn;
            w_wd_n    = AluWd;
        end else if (!w_empty) begin
            if (w_head.live) begin
                w_write_n = 1'b1;
                w_wn_n    = AW'(w_head.wn);
                w_wd_n    = DW'(w_head.wd);
            end
        end else if (w_bypass) begin
            w_write_n = 1'b1;
            w_wn_n    = LdWn;
            w_wd_n    = LdWd;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_write <= 1'b0;
            r_wn    <= '0;
            r_wd    <= '0;
        end else begin
            r_write <= w_write_n;
            r_wn    <= w_wn_n;
            r_wd    <= w_wd_n;
        end
    end

    assign Write   = r_write;
    assign Wn      = r_wn;
    assign Wd      = r_wd;
    assign Pending = w_mask;
    assign Count   = w_count;

endmodule
